// File: rtl/merlin_ibus_arbiter.sv
// Two-master instruction-bus arbiter. It forwards requests with zero added latency and
// steers responses back through an in-order ID tracker. Define MERLIN_IBUS_ARB_RR_EN for round-robin.
module merlin_ibus_arbiter #(
   parameter int C_OUTSTANDING_X = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   input  logic        r0_ireqvalid_i,
   output logic        r0_ireqready_o,
   input  logic [1:0]  r0_ireqhpl_i,
   input  logic [31:0] r0_ireqaddr_i,
   input  logic        r0_irspready_i,
   output logic        r0_irspvalid_o,
   output logic        r0_irsprerr_o,
   output logic [31:0] r0_irspdata_o,
   input  logic        r1_ireqvalid_i,
   output logic        r1_ireqready_o,
   input  logic [1:0]  r1_ireqhpl_i,
   input  logic [31:0] r1_ireqaddr_i,
   input  logic        r1_irspready_i,
   output logic        r1_irspvalid_o,
   output logic        r1_irsprerr_o,
   output logic [31:0] r1_irspdata_o,
   input  logic        m_ireqready_i,
   output logic        m_ireqvalid_o,
   output logic [1:0]  m_ireqhpl_o,
   output logic [31:0] m_ireqaddr_o,
   output logic        m_irspready_o,
   input  logic        m_irspvalid_i,
   input  logic        m_irsprerr_i,
   input  logic [31:0] m_irspdata_i,
   output logic        err_unexp_rsp_o
);
   localparam int DEPTH = 1 << C_OUTSTANDING_X;

   logic [C_OUTSTANDING_X:0]   level_q;
   logic [C_OUTSTANDING_X-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0]           id_q;
   logic                       lock_q, lock_id_q, err_q;
   logic                       gnt, gnt_vld, empty, full, head, pop, push, issue_ok;
`ifdef MERLIN_IBUS_ARB_RR_EN
   logic                       rr_q;
`endif

   // A locked grant holds the stalled master so its address stays stable until accepted.
   always_comb begin
      if (lock_q)
         gnt = lock_id_q;
`ifdef MERLIN_IBUS_ARB_RR_EN
      else if (r0_ireqvalid_i & r1_ireqvalid_i)
         gnt = ~rr_q;
`endif
      else
         gnt = ~r0_ireqvalid_i & r1_ireqvalid_i;
   end

   assign empty    = (level_q == '0);
   assign full     = (level_q == (C_OUTSTANDING_X+1)'(DEPTH));
   assign head     = id_q[rd_ptr_q];

   // Responses with nothing outstanding are sunk so they cannot stall the memory side.
   assign m_irspready_o  = empty | (head ? r1_irspready_i : r0_irspready_i);
   assign pop            = m_irspvalid_i & m_irspready_o & ~empty;
   assign issue_ok       = ~full | pop;

   assign gnt_vld        = gnt ? r1_ireqvalid_i : r0_ireqvalid_i;
   assign m_ireqvalid_o  = gnt_vld & issue_ok;
   assign m_ireqaddr_o   = gnt ? r1_ireqaddr_i : r0_ireqaddr_i;
   assign m_ireqhpl_o    = gnt ? r1_ireqhpl_i  : r0_ireqhpl_i;
   assign r0_ireqready_o = ~gnt & m_ireqready_i & issue_ok;
   assign r1_ireqready_o =  gnt & m_ireqready_i & issue_ok;
   assign push           = m_ireqvalid_o & m_ireqready_i;

   assign r0_irspvalid_o  = m_irspvalid_i & ~empty & ~head;
   assign r1_irspvalid_o  = m_irspvalid_i & ~empty &  head;
   assign r0_irsprerr_o   = m_irsprerr_i;
   assign r1_irsprerr_o   = m_irsprerr_i;
   assign r0_irspdata_o   = m_irspdata_i;
   assign r1_irspdata_o   = m_irspdata_i;
   assign err_unexp_rsp_o = err_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         level_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         id_q      <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         err_q     <= 1'b0;
`ifdef MERLIN_IBUS_ARB_RR_EN
         rr_q      <= 1'b0;
`endif
      end else if (clk_en_i) begin
         if (push) begin
            id_q[wr_ptr_q] <= gnt;
            wr_ptr_q       <= wr_ptr_q + 1'b1;
         end
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push & ~pop)
            level_q <= level_q + 1'b1;
         else if (pop & ~push)
            level_q <= level_q - 1'b1;
         // Lock drops on acceptance or when the locked master withdraws its request.
         lock_q <= gnt_vld & ~push;
         if (gnt_vld & ~push)
            lock_id_q <= gnt;
         if (m_irspvalid_i & empty)
            err_q <= 1'b1;
`ifdef MERLIN_IBUS_ARB_RR_EN
         if (push)
            rr_q <= gnt;
`endif
      end
   end
endmodule
